dff_share_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for one shared dual-rail storage flop (Q[1] = data, Q[0] = complement).
- NUM_REQ requesters each present a request and a one-bit data value.
- The arbiter grants one requester at a time and loads its bit into the shared flop.
- It holds the value for HOLD_CYCLES clocks, then acknowledges and moves to the next requester.
- Sits between the requesting control blocks and the shared storage element it owns.

---
 rtl/dff_arb_pkg.sv | 15 +
 rtl/dff_share_arbiter_rr_pick.sv | 41 ++++
 rtl/dff_share_arbiter.sv | 137 +++++++++++++
 tb/tb_dff_share_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_arb_pkg.sv
// Shared definitions for the dual-rail storage arbiter.
// Contents:
//   state_t  - sequencer states (IDLE, HOLD, RELEASE); code 2'd3 is unused
//   Q_RESET  - power-on value of the dual-rail flop (stored bit 0, complement 1)
package dff_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [1:0] Q_RESET = 2'b01;

endpackage

// File: rtl/dff_share_arbiter_rr_pick.sv
// Round-robin picker: purely combinational.
// Ports:
//   req     - request vector, one bit per requester
//   ptr     - index of the requester with highest priority this round
//   sel     - one-hot select of the winning requester (all zero when none)
//   idx     - binary index of the winner (0 when none)
//   any_req - at least one request is present
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] sel,
    output logic [IDX_W-1:0]   idx,
    output logic               any_req
);

    assign any_req = |req;

    // Scan starting at ptr and wrapping; the first hit wins.
    always_comb begin
        logic [IDX_W-1:0] j;
        logic             found;
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[j]) begin
                found  = 1'b1;
                sel[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter and sequencer owning one shared dual-rail storage flop.
// Each grant loads the winner's Din bit into Q, holds it for HOLD_CYCLES
// clocks, pulses Ack for one cycle, then rotates priority past the winner.
// Ports:
//   Clk    - rising-edge clock
//   Reset  - asynchronous, active-high reset
//   Req    - per-requester request level
//   Din    - per-requester data bit, sampled only at the grant edge
//   Grant  - one-hot grant, high for HOLD_CYCLES cycles per transaction
//   Ack    - one-hot single-cycle completion pulse
//   Q      - dual-rail storage: Q[1] = stored bit, Q[0] = its complement
//   Valid  - Q holds a currently granted value
//   Busy   - sequencer is not in IDLE
module dff_share_arbiter
    import dff_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 3
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [NUM_REQ-1:0] Req,
    input  logic [NUM_REQ-1:0] Din,
    output logic [NUM_REQ-1:0] Grant,
    output logic [NUM_REQ-1:0] Ack,
    output logic [1:0]         Q,
    output logic               Valid,
    output logic               Busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [IDX_W-1:0]   ptr, ptr_next;
    logic [IDX_W-1:0]   owner, owner_next;     // index of the current grantee
    logic [NUM_REQ-1:0] grant_next, ack_next;
    logic [1:0]         q_next;
    logic               valid_next, busy_next;

    logic [NUM_REQ-1:0] pick_sel;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (Req),
        .ptr     (ptr),
        .sel     (pick_sel),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= '0;
            owner <= '0;
            Grant <= '0;
            Ack   <= '0;
            Q     <= Q_RESET;
            Valid <= 1'b0;
            Busy  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ptr   <= ptr_next;
            owner <= owner_next;
            Grant <= grant_next;
            Ack   <= ack_next;
            Q     <= q_next;
            Valid <= valid_next;
            Busy  <= busy_next;
        end
    end

    // Next-state and next-output logic; everything holds unless a state
    // below says otherwise.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ptr_next   = ptr;
        owner_next = owner;
        grant_next = Grant;
        ack_next   = Ack;
        q_next     = Q;
        valid_next = Valid;
        busy_next  = Busy;

        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_next = pick_sel;
                    owner_next = pick_idx;
                    // Both rails come from one sampled bit, so they can
                    // never disagree.
                    q_next     = {Din[pick_idx], ~Din[pick_idx]};
                    valid_next = 1'b1;
                    busy_next  = 1'b1;
                    cnt_next   = CNT_W'(HOLD_CYCLES - 1);
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    grant_next = '0;
                    ack_next   = Grant;   // Grant is still one-hot of owner
                    valid_next = 1'b0;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                ack_next   = '0;
                ptr_next   = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                // Unused encoding: drop any partial transaction and resume.
                grant_next = '0;
                ack_next   = '0;
                valid_next = 1'b0;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Self-checking bench for dff_share_arbiter: directed scenarios plus a
// randomized run compared against a transaction-timeline model.
module tb_dff_share_arbiter;

    localparam int N = 4;
    localparam int H = 3;

    logic       Clk   = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] Req   = '0;
    logic [3:0] Din   = '0;
    logic [3:0] Req1  = '0;
    logic [3:0] Din1  = '0;

    logic [3:0] Grant, Ack, Grant1, Ack1;
    logic [1:0] Q, Q1;
    logic       Valid, Busy, Valid1, Busy1;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    dff_share_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(H)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Din(Din),
        .Grant(Grant), .Ack(Ack), .Q(Q), .Valid(Valid), .Busy(Busy)
    );

    dff_share_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(1)) dut_h1 (
        .Clk(Clk), .Reset(Reset), .Req(Req1), .Din(Din1),
        .Grant(Grant1), .Ack(Ack1), .Q(Q1), .Valid(Valid1), .Busy(Busy1)
    );

    // Reference model: a transaction is a timeline of H+2 clocks.
    // phase 0 = waiting, 1..H = value held with grant, H+1 = acknowledge.
    int   m_phase = 0;
    int   m_owner = 0;
    int   m_ptr   = 0;
    logic m_q     = 1'b0;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_phase = 0;
            m_owner = 0;
            m_ptr   = 0;
            m_q     = 1'b0;
        end else if (m_phase == 0) begin
            bit found;
            int j;
            found = 0;
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (!found && Req[j]) begin
                    found   = 1;
                    m_owner = j;
                end
            end
            if (found) begin
                m_q     = Din[m_owner];
                m_phase = 1;
            end
        end else if (m_phase <= H) begin
            m_phase++;
        end else begin
            m_phase = 0;
            m_ptr   = (m_owner + 1) % N;
        end
    end

    function automatic logic [3:0] onehot(int i);
        return 4'(1 << i);
    endfunction

    task automatic apply_reset();
        @(negedge Clk);
        Reset = 1'b1;
        Req   = '0;
        Req1  = '0;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        Req = 4'b0001;
        @(posedge Clk);
        #2;
        checks++; if (Grant !== 4'b0001) begin errors++; $display("FAIL reset pre-grant: got %b exp %b", Grant, 4'b0001); end
        Reset = 1'b1;
        #1;
        checks++; if (Q !== 2'b01) begin errors++; $display("FAIL reset Q: got %b exp %b", Q, 2'b01); end
        checks++; if (Grant !== 4'b0000) begin errors++; $display("FAIL reset Grant: got %b exp %b", Grant, 4'b0000); end
        checks++; if (Ack !== 4'b0000) begin errors++; $display("FAIL reset Ack: got %b exp %b", Ack, 4'b0000); end
        checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL reset Valid: got %b exp 0", Valid); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset Busy: got %b exp 0", Busy); end
        @(negedge Clk);
        Reset = 1'b0;
        Req   = '0;
    endtask

    task automatic test_single_grant();
        apply_reset();
        Req = 4'b0100;
        Din = 4'b0100;
        @(negedge Clk);
        checks++; if (Grant !== 4'b0100) begin errors++; $display("FAIL single e1 Grant: got %b exp %b", Grant, 4'b0100); end
        checks++; if (Q !== 2'b10) begin errors++; $display("FAIL single e1 Q: got %b exp %b", Q, 2'b10); end
        checks++; if (Valid !== 1'b1) begin errors++; $display("FAIL single e1 Valid: got %b exp 1", Valid); end
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL single e1 Busy: got %b exp 1", Busy); end
        Req = '0;
        for (int e = 2; e <= 3; e++) begin
            @(negedge Clk);
            checks++; if (Grant !== 4'b0100) begin errors++; $display("FAIL single e%0d Grant: got %b exp %b", e, Grant, 4'b0100); end
        end
        @(negedge Clk);
        checks++; if (Grant !== 4'b0000) begin errors++; $display("FAIL single e4 Grant: got %b exp %b", Grant, 4'b0000); end
        checks++; if (Ack !== 4'b0100) begin errors++; $display("FAIL single e4 Ack: got %b exp %b", Ack, 4'b0100); end
        checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL single e4 Valid: got %b exp 0", Valid); end
        @(negedge Clk);
        checks++; if (Ack !== 4'b0000) begin errors++; $display("FAIL single e5 Ack: got %b exp %b", Ack, 4'b0000); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL single e5 Busy: got %b exp 0", Busy); end
        checks++; if (Q !== 2'b10) begin errors++; $display("FAIL single e5 Q kept: got %b exp %b", Q, 2'b10); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        logic [1:0] exp_q;
        apply_reset();
        Req = 4'b1111;
        Din = 4'b1010;
        for (int e = 1; e <= 21; e++) begin
            int t, ph;
            @(negedge Clk);
            t  = (e - 1) / 5;
            ph = (e - 1) % 5;
            exp_g = (ph < H) ? onehot(t % N) : 4'b0000;
            checks++; if (Grant !== exp_g) begin errors++; $display("FAIL rr e%0d Grant: got %b exp %b", e, Grant, exp_g); end
            if (ph == 0) begin
                exp_q = (t % 2 == 0) ? 2'b01 : 2'b10;
                checks++; if (Q !== exp_q) begin errors++; $display("FAIL rr e%0d Q: got %b exp %b", e, Q, exp_q); end
            end
        end
        Req = '0;
    endtask

    task automatic test_din_ignored();
        apply_reset();
        Req = 4'b0010;
        Din = 4'b0010;
        for (int e = 1; e <= 5; e++) begin
            @(negedge Clk);
            checks++; if (Q !== 2'b10) begin errors++; $display("FAIL din_ign e%0d Q: got %b exp %b", e, Q, 2'b10); end
            if (e == 4) begin
                checks++; if (Ack !== 4'b0010) begin errors++; $display("FAIL din_ign e4 Ack: got %b exp %b", Ack, 4'b0010); end
            end
            Din = ~Din;
            if (e == 2) Req = '0;
        end
    endtask

    task automatic test_reset_mid_hold();
        apply_reset();
        Req = 4'b0100;
        @(negedge Clk);
        checks++; if (Grant !== 4'b0100) begin errors++; $display("FAIL mid_rst pre Grant: got %b exp %b", Grant, 4'b0100); end
        @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        checks++; if (Grant !== 4'b0000) begin errors++; $display("FAIL mid_rst Grant: got %b exp %b", Grant, 4'b0000); end
        @(negedge Clk);
        Req = 4'b1111;
        @(negedge Clk);
        Reset = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            @(negedge Clk);
            if (e == 1) begin
                checks++; if (Grant !== 4'b0001) begin errors++; $display("FAIL mid_rst first Grant: got %b exp %b", Grant, 4'b0001); end
            end
            checks++; if (Ack[2] !== 1'b0) begin errors++; $display("FAIL mid_rst e%0d Ack: got %b exp no bit 2", e, Ack); end
        end
        Req = '0;
    endtask

    task automatic test_hold_one();
        logic [3:0] d;
        d = 4'($urandom);
        apply_reset();
        Req1 = 4'b0011;
        Din1 = d;
        @(negedge Clk);
        checks++; if (Grant1 !== 4'b0001) begin errors++; $display("FAIL h1 e1 Grant: got %b exp %b", Grant1, 4'b0001); end
        checks++; if (Q1 !== {d[0], ~d[0]}) begin errors++; $display("FAIL h1 e1 Q: got %b exp %b", Q1, {d[0], ~d[0]}); end
        @(negedge Clk);
        checks++; if (Grant1 !== 4'b0000) begin errors++; $display("FAIL h1 e2 Grant: got %b exp %b", Grant1, 4'b0000); end
        checks++; if (Ack1 !== 4'b0001) begin errors++; $display("FAIL h1 e2 Ack: got %b exp %b", Ack1, 4'b0001); end
        @(negedge Clk);
        checks++; if (Ack1 !== 4'b0000) begin errors++; $display("FAIL h1 e3 Ack: got %b exp %b", Ack1, 4'b0000); end
        checks++; if (Busy1 !== 1'b0) begin errors++; $display("FAIL h1 e3 Busy: got %b exp 0", Busy1); end
        @(negedge Clk);
        checks++; if (Grant1 !== 4'b0010) begin errors++; $display("FAIL h1 e4 Grant: got %b exp %b", Grant1, 4'b0010); end
        checks++; if (Q1 !== {d[1], ~d[1]}) begin errors++; $display("FAIL h1 e4 Q: got %b exp %b", Q1, {d[1], ~d[1]}); end
        Req1 = '0;
    endtask

    task automatic test_random();
        logic [3:0] exp_g, exp_a;
        logic [1:0] exp_q;
        logic       exp_v, exp_b;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge Clk);
            exp_g = (m_phase >= 1 && m_phase <= H) ? onehot(m_owner) : 4'b0000;
            exp_a = (m_phase == H + 1) ? onehot(m_owner) : 4'b0000;
            exp_v = (m_phase >= 1 && m_phase <= H);
            exp_b = (m_phase != 0);
            exp_q = {m_q, ~m_q};
            checks++; if (Grant !== exp_g) begin errors++; $display("FAIL rand c%0d Grant: got %b exp %b", c, Grant, exp_g); end
            checks++; if (Ack !== exp_a) begin errors++; $display("FAIL rand c%0d Ack: got %b exp %b", c, Ack, exp_a); end
            checks++; if (Q !== exp_q) begin errors++; $display("FAIL rand c%0d Q: got %b exp %b", c, Q, exp_q); end
            checks++; if (Valid !== exp_v) begin errors++; $display("FAIL rand c%0d Valid: got %b exp %b", c, Valid, exp_v); end
            checks++; if (Busy !== exp_b) begin errors++; $display("FAIL rand c%0d Busy: got %b exp %b", c, Busy, exp_b); end
            checks++; if (Q[1] !== ~Q[0]) begin errors++; $display("FAIL rand c%0d dual-rail: got %b exp complementary rails", c, Q); end
            if ($urandom_range(0, 3) == 0) Req = 4'($urandom);
            Din = 4'($urandom);
        end
        Req = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_grant();
        test_round_robin();
        test_din_ignored();
        test_reset_mid_hold();
        test_hold_one();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
